// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall insertion, branch/jump redirect flush,
// EX-stage operand forwarding selects and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned N_STAGES     = 5,
  parameter int unsigned RESOLVE_IDX  = 3,
  parameter int unsigned LOAD_BUBBLES = 2,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   rs_ID,
  input  logic [ADDR_W-1:0]   rt_ID,
  input  logic [ADDR_W-1:0]   rs_EX,
  input  logic [ADDR_W-1:0]   rt_EX,
  input  logic [ADDR_W-1:0]   waddr_EX,
  input  logic                mem_read_EX,
  input  logic [ADDR_W-1:0]   waddr_MEM,
  input  logic                reg_write_MEM,
  input  logic                mem_2_reg_MEM,
  input  logic [ADDR_W-1:0]   waddr_WB,
  input  logic                reg_write_WB,
  input  logic                redirect_MEM,
  output logic [N_STAGES-1:0] pipeline_en,
  output logic [N_STAGES-1:0] flush,
  output logic [1:0]          fwd_rs,
  output logic [1:0]          fwd_rt,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // The hazard cycle itself is the first held cycle, so the counter only covers the rest.
  localparam logic [1:0]       BUB_LOAD = 2'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [1:0]          bub_q, bub_d;
  logic                load_use;
  logic                active;
  logic                stall_cond;
  logic                stall_hold;
  logic                accept_redirect;
  logic [N_STAGES-1:0] redirect_mask;
  logic [1:0]          fwd_rs_raw, fwd_rt_raw;

  assign load_use = mem_read_EX && (waddr_EX != '0) &&
                    ((waddr_EX == rs_ID) || (waddr_EX == rt_ID));

  assign active          = enable && (state_q != S_IDLE);
  assign stall_cond      = (state_q == S_STALL) || load_use;
  assign accept_redirect = active && redirect_MEM;
  assign stall_hold      = active && !redirect_MEM && stall_cond;

  assign state = state_q;

  always_comb begin
    redirect_mask = '0;
    for (int unsigned i = 0; i < N_STAGES; i++) begin
      redirect_mask[i] = (i >= 1) && (i <= RESOLVE_IDX);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    if (!enable) begin
      state_d = S_IDLE;
      bub_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          bub_d   = '0;
        end
        S_RUN, S_FLUSH: begin
          if (redirect_MEM) begin
            state_d = S_FLUSH;
            bub_d   = '0;
          end else if (load_use) begin
            bub_d   = BUB_LOAD;
            state_d = (BUB_LOAD != '0) ? S_STALL : S_RUN;
          end else begin
            state_d = S_RUN;
          end
        end
        S_STALL: begin
          if (redirect_MEM) begin
            state_d = S_FLUSH;
            bub_d   = '0;
          end else if (bub_q <= 2'd1) begin
            state_d = S_RUN;
            bub_d   = '0;
          end else begin
            bub_d = bub_q - 2'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          bub_d   = '0;
        end
      endcase
    end
  end

  // MEM-stage ALU result beats WB; a load in MEM cannot forward yet.
  always_comb begin
    fwd_rs_raw = 2'd0;
    fwd_rt_raw = 2'd0;
    if (reg_write_MEM && !mem_2_reg_MEM && (waddr_MEM != '0) && (waddr_MEM == rs_EX))
      fwd_rs_raw = 2'd2;
    else if (reg_write_WB && (waddr_WB != '0) && (waddr_WB == rs_EX))
      fwd_rs_raw = 2'd1;
    if (reg_write_MEM && !mem_2_reg_MEM && (waddr_MEM != '0) && (waddr_MEM == rt_EX))
      fwd_rt_raw = 2'd2;
    else if (reg_write_WB && (waddr_WB != '0) && (waddr_WB == rt_EX))
      fwd_rt_raw = 2'd1;
  end

  always_comb begin
    pipeline_en = '0;
    flush       = '0;
    fwd_rs      = 2'd0;
    fwd_rt      = 2'd0;
    if (active) begin
      pipeline_en = '1;
      fwd_rs      = fwd_rs_raw;
      fwd_rt      = fwd_rt_raw;
      if (redirect_MEM) begin
        flush = redirect_mask;
      end else if (stall_cond) begin
        pipeline_en[1:0] = 2'b00;
        flush[2]         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_hold && (stall_count != '1))
        stall_count <= stall_count + CNT_ONE;
      if (accept_redirect && (flush_count != '1))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic, two instances
// (default parameters, and LOAD_BUBBLES=3 / CNT_W=4) checked against a cycle model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, enable;
  logic [4:0] rs_ID, rt_ID, rs_EX, rt_EX, waddr_EX, waddr_MEM, waddr_WB;
  logic       mem_read_EX, reg_write_MEM, mem_2_reg_MEM, reg_write_WB, redirect_MEM;

  logic [4:0]  pipeline_en_a, flush_a, pipeline_en_b, flush_b;
  logic [1:0]  fwd_rs_a, fwd_rt_a, state_a, fwd_rs_b, fwd_rt_b, state_b;
  logic [15:0] stall_count_a, flush_count_a;
  logic [3:0]  stall_count_b, flush_count_b;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .waddr_EX(waddr_EX), .mem_read_EX(mem_read_EX),
    .waddr_MEM(waddr_MEM), .reg_write_MEM(reg_write_MEM), .mem_2_reg_MEM(mem_2_reg_MEM),
    .waddr_WB(waddr_WB), .reg_write_WB(reg_write_WB), .redirect_MEM(redirect_MEM),
    .pipeline_en(pipeline_en_a), .flush(flush_a), .fwd_rs(fwd_rs_a), .fwd_rt(fwd_rt_a),
    .stall_count(stall_count_a), .flush_count(flush_count_a), .state(state_a)
  );

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_EX(rs_EX), .rt_EX(rt_EX),
    .waddr_EX(waddr_EX), .mem_read_EX(mem_read_EX),
    .waddr_MEM(waddr_MEM), .reg_write_MEM(reg_write_MEM), .mem_2_reg_MEM(mem_2_reg_MEM),
    .waddr_WB(waddr_WB), .reg_write_WB(reg_write_WB), .redirect_MEM(redirect_MEM),
    .pipeline_en(pipeline_en_b), .flush(flush_b), .fwd_rs(fwd_rs_b), .fwd_rt(fwd_rt_b),
    .stall_count(stall_count_b), .flush_count(flush_count_b), .state(state_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: "running" flag, remaining held cycles after this one,
  // whether the previous cycle accepted a redirect, and plain integer counters.
  bit m_run[2];
  int m_hold[2];
  bit m_red[2];
  int m_stall[2];
  int m_flush[2];

  function automatic int lb_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int max_of(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic bit hazard_now();
    return mem_read_EX && (waddr_EX != 0) && ((waddr_EX == rs_ID) || (waddr_EX == rt_ID));
  endfunction

  function automatic int fwd_of(input logic [4:0] src);
    if (reg_write_MEM && !mem_2_reg_MEM && (waddr_MEM != 0) && (waddr_MEM == src)) return 2;
    if (reg_write_WB && (waddr_WB != 0) && (waddr_WB == src)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_hold[k] = 0; m_red[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic model_edge();
    if (!arst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!enable) begin
          m_run[k] = 0; m_hold[k] = 0; m_red[k] = 0;
        end else if (!m_run[k]) begin
          m_run[k] = 1; m_hold[k] = 0; m_red[k] = 0;
        end else if (redirect_MEM) begin
          if (m_flush[k] < max_of(k)) m_flush[k]++;
          m_hold[k] = 0; m_red[k] = 1;
        end else if (m_hold[k] > 0) begin
          if (m_stall[k] < max_of(k)) m_stall[k]++;
          m_hold[k]--; m_red[k] = 0;
        end else if (hazard_now()) begin
          if (m_stall[k] < max_of(k)) m_stall[k]++;
          m_hold[k] = lb_of(k) - 1; m_red[k] = 0;
        end else begin
          m_red[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int e_en, e_fl, e_rs, e_rt, e_st;
    logic [31:0] g_en, g_fl, g_rs, g_rt, g_st, g_sc, g_fc;
    for (int k = 0; k < 2; k++) begin
      e_en = 0; e_fl = 0; e_rs = 0; e_rt = 0;
      if (m_run[k] && enable && arst_n) begin
        e_rs = fwd_of(rs_EX);
        e_rt = fwd_of(rt_EX);
        if (redirect_MEM) begin
          e_en = 5'b11111; e_fl = 5'b01110;
        end else if ((m_hold[k] > 0) || hazard_now()) begin
          e_en = 5'b11100; e_fl = 5'b00100;
        end else begin
          e_en = 5'b11111;
        end
      end
      e_st = !m_run[k] ? 0 : (m_hold[k] > 0) ? 2 : m_red[k] ? 3 : 1;
      if (k == 0) begin
        g_en = 32'(pipeline_en_a); g_fl = 32'(flush_a); g_rs = 32'(fwd_rs_a);
        g_rt = 32'(fwd_rt_a); g_st = 32'(state_a);
        g_sc = 32'(stall_count_a); g_fc = 32'(flush_count_a);
      end else begin
        g_en = 32'(pipeline_en_b); g_fl = 32'(flush_b); g_rs = 32'(fwd_rs_b);
        g_rt = 32'(fwd_rt_b); g_st = 32'(state_b);
        g_sc = 32'(stall_count_b); g_fc = 32'(flush_count_b);
      end
      check_eq($sformatf("i%0d_pipeline_en", k), g_en, 32'(e_en));
      check_eq($sformatf("i%0d_flush", k), g_fl, 32'(e_fl));
      check_eq($sformatf("i%0d_fwd_rs", k), g_rs, 32'(e_rs));
      check_eq($sformatf("i%0d_fwd_rt", k), g_rt, 32'(e_rt));
      check_eq($sformatf("i%0d_state", k), g_st, 32'(e_st));
      check_eq($sformatf("i%0d_stall_count", k), g_sc, 32'(m_stall[k]));
      check_eq($sformatf("i%0d_flush_count", k), g_fc, 32'(m_flush[k]));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    rs_ID = 0; rt_ID = 0; rs_EX = 0; rt_EX = 0; waddr_EX = 0; waddr_MEM = 0; waddr_WB = 0;
    mem_read_EX = 0; reg_write_MEM = 0; mem_2_reg_MEM = 0; reg_write_WB = 0; redirect_MEM = 0;
  endtask

  task automatic set_load_use();
    mem_read_EX = 1; waddr_EX = 5'd8; rs_ID = 5'd8;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int unsigned s0;
    clear_inputs();
    enable = 0;
    arst_n = 0;
    #2;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1 arst_n = 1;

    // enable raised in cycle 2 after release
    settle(); tick();
    settle(); tick();
    enable = 1;
    settle(); check_eq("c2_en_idle", 32'(pipeline_en_a), 32'd0); tick();
    settle(); check_eq("c3_en_run", 32'(pipeline_en_a), 32'h1f);
    check_eq("c3_state", 32'(state_a), 32'd1); tick();

    // load-use, two bubbles on instance a
    set_load_use();
    settle(); check_eq("lu_en1", 32'(pipeline_en_a), 32'h1c);
    check_eq("lu_flush1", 32'(flush_a), 32'h04); tick();
    clear_inputs();
    settle(); check_eq("lu_en2", 32'(pipeline_en_a), 32'h1c);
    check_eq("lu_flush2", 32'(flush_a), 32'h04); tick();
    settle(); check_eq("lu_en3", 32'(pipeline_en_a), 32'h1f);
    check_eq("lu_stall_count", 32'(stall_count_a), 32'd2); tick();
    repeat (3) begin settle(); tick(); end

    // redirect during second stall cycle
    set_load_use();
    settle(); tick();
    clear_inputs(); redirect_MEM = 1;
    settle(); check_eq("rd_en", 32'(pipeline_en_a), 32'h1f);
    check_eq("rd_flush", 32'(flush_a), 32'h0e); tick();
    redirect_MEM = 0;
    settle(); check_eq("rd_state_flush", 32'(state_a), 32'd3);
    check_eq("rd_no_stall", 32'(pipeline_en_a), 32'h1f);
    check_eq("rd_flush_count", 32'(flush_count_a), 32'd1); tick();

    // forwarding priority
    rs_EX = 4; rt_EX = 4; waddr_MEM = 4; reg_write_MEM = 1; waddr_WB = 4; reg_write_WB = 1;
    settle(); check_eq("fw_mem_rs", 32'(fwd_rs_a), 32'd2);
    check_eq("fw_mem_rt", 32'(fwd_rt_a), 32'd2); tick();
    mem_2_reg_MEM = 1;
    settle(); check_eq("fw_wb_rs", 32'(fwd_rs_a), 32'd1);
    check_eq("fw_wb_rt", 32'(fwd_rt_a), 32'd1); tick();
    mem_2_reg_MEM = 0; waddr_MEM = 0; waddr_WB = 0;
    settle(); check_eq("fw_r0_rs", 32'(fwd_rs_a), 32'd0);
    check_eq("fw_r0_rt", 32'(fwd_rt_a), 32'd0); tick();
    clear_inputs();
    repeat (2) begin settle(); tick(); end

    // simultaneous load-use and redirect: redirect wins
    s0 = 32'(stall_count_a);
    set_load_use(); redirect_MEM = 1;
    settle(); check_eq("both_flush", 32'(flush_a), 32'h0e);
    check_eq("both_en", 32'(pipeline_en_a), 32'h1f); tick();
    clear_inputs();
    settle(); check_eq("both_stall_count", 32'(stall_count_a), s0);
    check_eq("both_state", 32'(state_a), 32'd3); tick();

    // persistent hazard saturates the 4-bit counter on instance b
    set_load_use();
    repeat (24) begin settle(); tick(); end
    settle(); check_eq("sat_stall_count_b", 32'(stall_count_b), 32'd15); tick();
    clear_inputs();
    repeat (4) begin settle(); tick(); end

    // enable dropped mid-stall
    set_load_use();
    settle(); tick();
    clear_inputs(); enable = 0;
    settle(); check_eq("dis_en", 32'(pipeline_en_a), 32'd0);
    check_eq("dis_flush", 32'(flush_a), 32'd0); tick();
    settle(); check_eq("dis_state_idle", 32'(state_a), 32'd0); tick();
    enable = 1;
    settle(); tick();

    // reset mid-stall, then wait in IDLE until enable
    set_load_use();
    settle(); tick();
    clear_inputs();
    #2 arst_n = 0;
    #1 model_reset(); compare_all();
    check_eq("rst_state", 32'(state_a), 32'd0);
    check_eq("rst_en", 32'(pipeline_en_a), 32'd0);
    tick();
    enable = 0; arst_n = 1;
    settle(); tick();
    settle(); check_eq("rst_wait_idle", 32'(state_a), 32'd0); tick();
    enable = 1;
    settle(); tick();
    settle(); check_eq("rst_resume", 32'(state_a), 32'd1); tick();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        arst_n = 0;
        #1 model_reset(); compare_all();
        tick();
        arst_n = 1;
      end
      enable        = ($urandom_range(0, 19) != 0);
      rs_ID         = 5'($urandom_range(0, 3));
      rt_ID         = 5'($urandom_range(0, 3));
      rs_EX         = 5'($urandom_range(0, 3));
      rt_EX         = 5'($urandom_range(0, 3));
      waddr_EX      = 5'($urandom_range(0, 3));
      waddr_MEM     = 5'($urandom_range(0, 3));
      waddr_WB      = 5'($urandom_range(0, 3));
      mem_read_EX   = 1'($urandom_range(0, 1));
      reg_write_MEM = 1'($urandom_range(0, 1));
      mem_2_reg_MEM = 1'($urandom_range(0, 1));
      reg_write_WB  = 1'($urandom_range(0, 1));
      redirect_MEM  = ($urandom_range(0, 9) == 0);
      settle(); tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
